// File: rtl/life_pkg.sv
// Shared types and the neighbour-count helper for the 8x8 Game of Life engine.
package life_pkg;

    localparam int GRID_W = 64;
    localparam int GRID_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } life_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_EXTINCT = 3'd1,
        CAUSE_STABLE  = 3'd2,
        CAUSE_OSC2    = 3'd3,
        CAUSE_LIMIT   = 3'd4
    } halt_cause_t;

    // Cells outside the 8x8 board are dead; the board does not wrap.
    function automatic logic [3:0] live_neighbours(input logic [GRID_W-1:0] g,
                                                   input int r, input int c);
        logic [3:0] n;
        n = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) &&
                    r + dr >= 0 && r + dr < GRID_N &&
                    c + dc >= 0 && c + dc < GRID_N) begin
                    n = n + {3'b000, g[6'((r + dr) * GRID_N + (c + dc))]};
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/life_datapath.sv
// Combinational next-generation block: applies the B3/S23 rule to every cell.
module datapath
    import life_pkg::*;
(
    input  logic [GRID_W-1:0] grid,
    output logic [GRID_W-1:0] grid_evolve
);

    always_comb begin
        grid_evolve = '0;
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N; c++) begin
                grid_evolve[6'(r * GRID_N + c)] =
                    (live_neighbours(grid, r, c) == 4'd3) ||
                    (grid[6'(r * GRID_N + c)] && live_neighbours(grid, r, c) == 4'd2);
            end
        end
    end

endmodule

// File: rtl/life_controller.sv
// Generation sequencer: load/run/step/halt control around the datapath.
// Optional period-2 oscillator detection is built when LIFE_PERIOD2_DETECT_EN is defined.
module life_controller
    import life_pkg::*;
#(
    parameter int                GEN_W   = 16,
    parameter logic [GEN_W-1:0]  GEN_MAX = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] seed,
    input  logic              load,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              tick,
    output logic [GRID_W-1:0] grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic              running,
    output logic              halted,
    output logic [2:0]        halt_cause
);

    life_state_t state, state_next;
    halt_cause_t cause, cause_next;
    logic [GRID_W-1:0] evolve;
    logic do_load, do_update;

`ifdef LIFE_PERIOD2_DETECT_EN
    logic [GRID_W-1:0] prev_grid;
    logic              prev_valid;
`endif

    datapath u_datapath (
        .grid        (grid),
        .grid_evolve (evolve)
    );

    // Pulse priority is stop > load > start > step; reset is handled in the register block.
    always_comb begin
        state_next = state;
        cause_next = cause;
        do_load    = 1'b0;
        do_update  = 1'b0;
        case (state)
            IDLE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (load) begin
                    do_load = 1'b1;
                end else if (start) begin
                    state_next = RUN;
                end else if (step) begin
                    do_update = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (load) begin
                    do_load    = 1'b1;
                    state_next = IDLE;
                end else if (tick) begin
                    if (grid == '0) begin
                        state_next = HALT;
                        cause_next = CAUSE_EXTINCT;
                    end else if (evolve == grid) begin
                        state_next = HALT;
                        cause_next = CAUSE_STABLE;
`ifdef LIFE_PERIOD2_DETECT_EN
                    end else if (prev_valid && evolve == prev_grid) begin
                        state_next = HALT;
                        cause_next = CAUSE_OSC2;
`endif
                    end else if (gen_count == GEN_MAX) begin
                        state_next = HALT;
                        cause_next = CAUSE_LIMIT;
                    end else begin
                        do_update = 1'b1;
                    end
                end
            end
            HALT: begin
                if (stop) begin
                    state_next = IDLE;
                    cause_next = CAUSE_NONE;
                end else if (load) begin
                    do_load    = 1'b1;
                    state_next = IDLE;
                    cause_next = CAUSE_NONE;
                end else if (start) begin
                    state_next = RUN;
                    cause_next = CAUSE_NONE;
                end else if (step) begin
                    do_update = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cause_next = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cause     <= CAUSE_NONE;
            grid      <= '0;
            gen_count <= '0;
        end else begin
            state <= state_next;
            cause <= cause_next;
            if (do_load) begin
                grid      <= seed;
                gen_count <= '0;
            end else if (do_update) begin
                grid      <= evolve;
                gen_count <= (gen_count == '1) ? gen_count : gen_count + GEN_W'(1);
            end
        end
    end

`ifdef LIFE_PERIOD2_DETECT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_grid  <= '0;
            prev_valid <= 1'b0;
        end else if (do_load) begin
            prev_valid <= 1'b0;
        end else if (do_update) begin
            prev_grid  <= grid;
            prev_valid <= 1'b1;
        end
    end
`endif

    assign running    = (state == RUN);
    assign halted     = (state == HALT);
    assign halt_cause = cause;

endmodule

// File: tb/tb_life_controller.sv
// Bench for life_controller: each cycle pushes the expected outputs, then pops and compares after the edge.
module tb_life_controller;

    localparam int OBS_W = 64 + 16 + 1 + 1 + 3;

    localparam logic [63:0] BLOCK   = 64'h0000_0000_0006_0600;
    localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;
    localparam logic [63:0] BLINK_H = 64'h0000_0000_000E_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0000_0404_0400;

    localparam logic [2:0] C_NONE    = 3'd0;
    localparam logic [2:0] C_EXTINCT = 3'd1;
    localparam logic [2:0] C_STABLE  = 3'd2;
    localparam logic [2:0] C_OSC2    = 3'd3;
    localparam logic [2:0] C_LIMIT   = 3'd4;

    typedef struct packed {
        logic [63:0] grid;
        logic [15:0] gen;
        logic        run;
        logic        halt;
        logic [2:0]  cause;
    } obs_t;

    logic        clk;
    logic        reset;
    logic [63:0] seed;
    logic        load, start, stop, step, tick;
    logic [63:0] grid;
    logic [15:0] gen_count;
    logic        running, halted;
    logic [2:0]  halt_cause;

    logic [OBS_W-1:0] exp_q[$];
    int n_checks;
    int n_pass;

    life_controller #(
        .GEN_W   (16),
        .GEN_MAX (16'd5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seed       (seed),
        .load       (load),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .tick       (tick),
        .grid       (grid),
        .gen_count  (gen_count),
        .running    (running),
        .halted     (halted),
        .halt_cause (halt_cause)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [OBS_W-1:0] mk(input logic [63:0] g, input logic [15:0] n,
                                             input logic r, input logic h, input logic [2:0] c);
        obs_t o;
        o.grid = g; o.gen = n; o.run = r; o.halt = h; o.cause = c;
        return o;
    endfunction

    // One clock of stimulus: {rst, load, start, stop, step, tick}, then compare after the edge.
    task automatic cycle(input string tag, input logic [5:0] cmd, input logic [63:0] sd,
                         input logic [OBS_W-1:0] exp);
        obs_t e;
        @(negedge clk);
        {reset, load, start, stop, step, tick} = cmd;
        seed = sd;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        {reset, load, start, stop, step, tick} = 6'b0;
        e = obs_t'(exp_q.pop_front());
        check({tag, ".grid"},  grid,                 e.grid);
        check({tag, ".gen"},   64'(gen_count),       64'(e.gen));
        check({tag, ".run"},   64'(running),         64'(e.run));
        check({tag, ".halt"},  64'(halted),          64'(e.halt));
        check({tag, ".cause"}, 64'(halt_cause),      64'(e.cause));
    endtask

    localparam logic [5:0] RST = 6'b100000;
    localparam logic [5:0] LD  = 6'b010000;
    localparam logic [5:0] ST  = 6'b001000;
    localparam logic [5:0] SP  = 6'b000100;
    localparam logic [5:0] STP = 6'b000010;
    localparam logic [5:0] TK  = 6'b000001;
    localparam logic [5:0] NOP = 6'b000000;

    initial begin
        logic [63:0] g;
        n_checks = 0;
        n_pass   = 0;
        {reset, load, start, stop, step, tick} = 6'b0;
        seed = '0;

        cycle("reset0", RST, '0, mk('0, 0, 0, 0, C_NONE));
        cycle("reset1", RST, 64'hFFFF, mk('0, 0, 0, 0, C_NONE));

        // block still life
        cycle("blk_load",  LD, BLOCK, mk(BLOCK, 0, 0, 0, C_NONE));
        cycle("blk_start", ST, '0, mk(BLOCK, 0, 1, 0, C_NONE));
        cycle("blk_tick",  TK, '0, mk(BLOCK, 0, 0, 1, C_STABLE));
        cycle("blk_hold",  NOP, '0, mk(BLOCK, 0, 0, 1, C_STABLE));
        cycle("blk_hstep", STP, '0, mk(BLOCK, 1, 0, 1, C_STABLE));
        cycle("blk_hstop", SP, '0, mk(BLOCK, 1, 0, 0, C_NONE));

        // extinction
        cycle("ext_load",  LD, SINGLE, mk(SINGLE, 0, 0, 0, C_NONE));
        cycle("ext_start", ST, '0, mk(SINGLE, 0, 1, 0, C_NONE));
        cycle("ext_tick1", TK, '0, mk('0, 1, 1, 0, C_NONE));
        cycle("ext_tick2", TK, '0, mk('0, 1, 0, 1, C_EXTINCT));

        // blinker
        cycle("bl_load",  LD, BLINK_H, mk(BLINK_H, 0, 0, 0, C_NONE));
        cycle("bl_start", ST, '0, mk(BLINK_H, 0, 1, 0, C_NONE));
        cycle("bl_tick1", TK, '0, mk(BLINK_V, 1, 1, 0, C_NONE));
        cycle("bl_notick", NOP, '0, mk(BLINK_V, 1, 1, 0, C_NONE));
        cycle("bl_stepign", STP, '0, mk(BLINK_V, 1, 1, 0, C_NONE));
`ifdef LIFE_PERIOD2_DETECT_EN
        cycle("bl_osc2",   TK, '0, mk(BLINK_V, 1, 0, 1, C_OSC2));
        cycle("bl_restart", ST, '0, mk(BLINK_V, 1, 1, 0, C_NONE));
        cycle("bl_rehalt", TK, '0, mk(BLINK_V, 1, 0, 1, C_OSC2));
`else
        for (int k = 2; k <= 5; k++) begin
            g = (k % 2 == 1) ? BLINK_V : BLINK_H;
            cycle($sformatf("bl_tick%0d", k), TK, '0, mk(g, 16'(k), 1, 0, C_NONE));
        end
        cycle("bl_limit",   TK, '0, mk(BLINK_V, 5, 0, 1, C_LIMIT));
        cycle("bl_restart", ST, '0, mk(BLINK_V, 5, 1, 0, C_NONE));
        cycle("bl_rehalt",  TK, '0, mk(BLINK_V, 5, 0, 1, C_LIMIT));
`endif

        // commands
        cycle("cmd_load",    LD, BLOCK, mk(BLOCK, 0, 0, 0, C_NONE));
        cycle("cmd_step",    STP, '0, mk(BLOCK, 1, 0, 0, C_NONE));
        cycle("cmd_start",   ST, '0, mk(BLOCK, 1, 1, 0, C_NONE));
        cycle("cmd_stopst",  SP | ST, '0, mk(BLOCK, 1, 0, 0, C_NONE));
        cycle("cmd_load2",   LD, BLINK_H, mk(BLINK_H, 0, 0, 0, C_NONE));
        cycle("cmd_start2",  ST, '0, mk(BLINK_H, 0, 1, 0, C_NONE));
        cycle("cmd_tick",    TK, '0, mk(BLINK_V, 1, 1, 0, C_NONE));
        cycle("cmd_stop_tk", SP | TK, '0, mk(BLINK_V, 1, 0, 0, C_NONE));
        cycle("cmd_start3",  ST, '0, mk(BLINK_V, 1, 1, 0, C_NONE));
        cycle("cmd_reset",   RST | TK | LD, BLOCK, mk('0, 0, 0, 0, C_NONE));
        cycle("cmd_after",   NOP, '0, mk('0, 0, 0, 0, C_NONE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
